// File: rtl/dtm_dmi_bridge.sv
// dtm_dmi_bridge: DTM register bank (IDCODE/DTMCS/DMI) driving a DMI master with one outstanding request.
module dtm_dmi_bridge #(
  parameter int ABITS = 7,
  parameter int DATA_W = 32,
  parameter int IR_W = 5,
  parameter logic [2:0] IDLE_HINT = 3'd2,
  parameter logic [31:0] IDCODE = 32'h1000_1003,
  parameter int RSP_TIMEOUT = 255,
  localparam int DMI_W = ABITS + DATA_W + 2
) (
  input  logic              dtm_clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DMI_W-1:0]  wr_data,
  output logic              wr_rdy,
  input  logic              capture_en,
  input  logic [IR_W-1:0]   capture_addr,
  output logic [DMI_W-1:0]  capture_data,
  output logic              dmi_req_vld,
  input  logic              dmi_req_rdy,
  output logic [ABITS-1:0]  dmi_req_addr,
  output logic [DATA_W-1:0] dmi_req_data,
  output logic [1:0]        dmi_req_op,
  input  logic              dmi_rsp_vld,
  output logic              dmi_rsp_rdy,
  input  logic [DATA_W-1:0] dmi_rsp_data,
  input  logic [1:0]        dmi_rsp_op
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(8'h01);
  localparam logic [IR_W-1:0] IR_DTMCS = IR_W'(8'h10);
  localparam logic [IR_W-1:0] IR_DMI = IR_W'(8'h11);
  localparam int CW = RSP_TIMEOUT > 0 ? $clog2(RSP_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = RSP_TIMEOUT > 0 ? CW'(RSP_TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX = CW'(RSP_TIMEOUT);
  localparam logic [5:0] ABITS_F = 6'(ABITS);
  state_e state_q, state_d;
  logic [1:0] dmistat_q, dmistat_d, op_q, op_d, wr_op, op_field;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d, rd_data_q, rd_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] dtmcs;
  logic ir_dmi, ir_cs, upd_dmi, upd_cs, hard, clr, start, busy_ev, rsp_done, timeout, fail_ev;
  assign ir_dmi = capture_addr == IR_DMI;
  assign ir_cs = capture_addr == IR_DTMCS;
  assign upd_dmi = wr_en && ir_dmi;
  assign upd_cs = wr_en && ir_cs;
  assign hard = upd_cs && wr_data[17];
  assign clr = upd_cs && wr_data[16];
  assign wr_op = wr_data[1:0];
  assign start = upd_dmi && dmistat_q == 2'd0 && state_q == IDLE && (wr_op == 2'd1 || wr_op == 2'd2);
  assign busy_ev = (upd_dmi || (capture_en && ir_dmi)) && state_q != IDLE;
  assign rsp_done = state_q == WAIT && dmi_rsp_vld;
  assign timeout = RSP_TIMEOUT > 0 && state_q == WAIT && !dmi_rsp_vld && cnt_q == CNT_LAST;
  assign fail_ev = (rsp_done && dmi_rsp_op != 2'd0) || timeout;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    data_d = data_q;
    op_d = op_q;
    rd_data_d = rd_data_q;
    cnt_d = cnt_q == CNT_MAX ? cnt_q : cnt_q + CW'(1);
    if (start) begin
      state_d = REQ;
      addr_d = wr_data[DMI_W-1:DATA_W+2];
      data_d = wr_data[DATA_W+1:2];
      op_d = wr_op;
    end
    if (state_q == REQ && dmi_req_rdy) begin
      state_d = WAIT;
      cnt_d = '0;
    end
    if (rsp_done) begin
      state_d = IDLE;
      rd_data_d = dmi_rsp_data;
    end
    if (timeout) state_d = IDLE;
    // hardreset abandons the transaction, including a response landing this cycle
    if (hard) begin
      state_d = IDLE;
      rd_data_d = rd_data_q;
    end
    dmistat_d = (hard || clr) ? 2'd0 : dmistat_q != 2'd0 ? dmistat_q :
                fail_ev ? 2'd2 : busy_ev ? 2'd3 : 2'd0;
  end
  always_ff @(posedge dtm_clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dmistat_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      op_q <= '0;
      rd_data_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      dmistat_q <= dmistat_d;
      addr_q <= addr_d;
      data_q <= data_d;
      op_q <= op_d;
      rd_data_q <= rd_data_d;
      cnt_q <= cnt_d;
    end
  end
  assign wr_rdy = 1'b1;
  assign dmi_rsp_rdy = 1'b1;
  assign dmi_req_vld = state_q == REQ;
  assign dmi_req_addr = addr_q;
  assign dmi_req_data = data_q;
  assign dmi_req_op = op_q;
  assign op_field = dmistat_q != 2'd0 ? dmistat_q : state_q != IDLE ? 2'd3 : 2'd0;
  assign dtmcs = {14'd0, 2'd0, 1'b0, IDLE_HINT, dmistat_q, ABITS_F, 4'd1};
  assign capture_data = ir_dmi ? {addr_q, rd_data_q, op_field} :
                        capture_addr == IR_IDCODE ? DMI_W'(IDCODE) :
                        ir_cs ? DMI_W'(dtmcs) : '0;
endmodule
